// File: rtl/ahb_bus_arbiter.sv
`timescale 1ns/1ps
// ahb_bus_arbiter: registered one-hot AHB grant with burst and locked-sequence hold.
// Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module ahb_bus_arbiter #(
    parameter int unsigned NUM_MASTERS    = 3,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MW             = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic                   HREADY,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    typedef enum logic [1:0] {StArb, StBurst, StLocked} arb_state_e;

    localparam logic [1:0] TransIdle   = 2'd0;
    localparam logic [1:0] TransBusy   = 2'd1;
    localparam logic [1:0] TransNonseq = 2'd2;
    localparam logic [1:0] TransSeq    = 2'd3;
    localparam logic [2:0] BurstIncr   = 3'd1;

    localparam logic [MW-1:0]          DefIdx   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] GrantOne = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] DefGrant = GrantOne << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          owner_q, owner_d;
    logic [MW-1:0]          master_q, master_d;
    logic                   mastlock_q, mastlock_d;
    logic [4:0]             cnt_q, cnt_d;
`ifndef ARB_FIXED_PRIORITY_EN
    logic [MW-1:0]          ptr_q, ptr_d;
`endif
    arb_state_e             arb_state;
    logic [MW-1:0]          winner;
    logic [MW-1:0]          cand;
    logic                   found;
    logic                   keep_incr;

    // Beats remaining after the NONSEQ beat; SINGLE and INCR both load zero.
    function automatic logic [4:0] beats_m1(input logic [1:0] burst_len_sel);
        case (burst_len_sel)
            2'b00:   return 5'd0;
            2'b01:   return 5'd3;
            2'b10:   return 5'd7;
            default: return 5'd15;
        endcase
    endfunction

    always_comb begin
        grant_d    = grant_q;
        owner_d    = owner_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;
        cnt_d      = cnt_q;
`ifndef ARB_FIXED_PRIORITY_EN
        ptr_d      = ptr_q;
`endif
        arb_state  = StArb;
        winner     = DefIdx;
        cand       = DefIdx;
        found      = 1'b0;
        keep_incr  = 1'b0;

        if (HREADY) begin
            master_d   = owner_q;
            mastlock_d = HLOCK[owner_q];

            case (HTRANS)
                TransNonseq: cnt_d = beats_m1(HBURST[2:1]);
                TransSeq:    cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                TransBusy:   cnt_d = cnt_q;
                default:     cnt_d = 5'd0;
            endcase

            if (HLOCK[owner_q] && HBUSREQ[owner_q]) begin
                arb_state = StLocked;
            end else if (cnt_d != 5'd0) begin
                arb_state = StBurst;
            end else begin
                arb_state = StArb;
            end

            // An undefined-length INCR burst keeps the bus only while its owner keeps asking.
            keep_incr = HBUSREQ[owner_q] && (HBURST == BurstIncr) && (HTRANS != TransIdle);

            if (arb_state == StArb && !keep_incr) begin
`ifdef ARB_FIXED_PRIORITY_EN
                for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                    cand = MW'(i);
                    if (!found && HBUSREQ[cand]) begin
                        found  = 1'b1;
                        winner = cand;
                    end
                end
`else
                for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
                    cand = MW'((32'(ptr_q) + k) % NUM_MASTERS);
                    if (!found && HBUSREQ[cand]) begin
                        found  = 1'b1;
                        winner = cand;
                    end
                end
                if (found) begin
                    ptr_d = winner;
                end
`endif
                owner_d = found ? winner : DefIdx;
                grant_d = found ? (GrantOne << winner) : DefGrant;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_q    <= DefGrant;
            owner_q    <= DefIdx;
            master_q   <= DefIdx;
            mastlock_q <= 1'b0;
            cnt_q      <= 5'd0;
`ifndef ARB_FIXED_PRIORITY_EN
            ptr_q      <= DefIdx;
`endif
        end else begin
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
            cnt_q      <= cnt_d;
`ifndef ARB_FIXED_PRIORITY_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTLOCK = mastlock_q;

endmodule
